divider_seq: RTL and testbench
==============================

# divider_seq

Sequential 32-bit integer divider that serves the multi-cycle CPU's `div` request. The control unit asserts `start` with operands from registers A and B. The block runs a restoring shift-subtract division, one quotient bit per clock. It then returns quotient and remainder to the Div inputs of the LO/HI muxes, with a one-cycle `done` pulse and a divide-by-zero flag for the exception path.

## Interface

Parameters:
- `WIDTH`, 32, operand/result width. The iteration counter is $clog2(WIDTH)+1 bits wide.

Ports:
- `clock` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request. Sampled only in IDLE.
- `a` input WIDTH: dividend (register A). Captured on the accepting edge.
- `b` input WIDTH: divisor (register B). Captured on the accepting edge.
- `is_unsigned` input 1: present only with `DIV_UNSIGNED_EN`. Captured with the operands.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: high for exactly one cycle, in DONE.
- `div_zero` output 1: high together with `done` when the captured divisor was 0.
- `hi` output WIDTH: remainder, registered.
- `lo` output WIDTH: quotient, registered.

## Operation

States: IDLE, RUN, DONE.

IDLE:
- `start`=1 with `b`≠0:
  - Capture |a| into the dividend shift register, |b| into the divisor register, and both operand signs.
  - Clear the partial remainder.
  - Set the counter to WIDTH.
  - Go to RUN.
- `start`=1 with `b`=0:
  - Go straight to DONE with the `div_zero` flag set.
  - `hi`/`lo` keep their previous values.

RUN, one step per edge:
- Shift {rem, dvd} left by 1.
- Trial value: rem − divisor. If it is non-negative, rem takes the trial value and the quotient LSB is set to 1; otherwise the quotient LSB is 0.
- Decrement the counter.
- When the counter reaches 0 on this edge:
  - Load `lo`/`hi` with the sign-corrected results.
  - Go to DONE.

DONE:
- `done`=1. `div_zero` = the captured zero flag.
- Next edge: go to IDLE unconditionally. `done` and `div_zero` drop.

Arithmetic rules:
- Signed mode:
  - Quotient truncates toward zero. It is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Magnitudes are computed as WIDTH-bit unsigned values.
- Overflow case −2^31 / −1: `lo`=0x80000000, `hi`=0. No flag is raised.
- `start` in RUN or DONE is ignored.
- Changes on `a`/`b` after the accepting edge have no effect.

Reset (asynchronous, whenever `reset`=0):
- State goes to IDLE. Counter cleared.
- `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0.
- An in-flight division is aborted. No `done` is produced.

## Timing

- Call the accepting edge E0.
- Non-zero divisor:
  - Iterations occur on edges E1..E32.
  - `hi`/`lo` are valid and `done`=1 during the cycle after E32.
  - Return to IDLE at E33. `busy` is high from after E0 through E33.
  - Earliest next accept is E34, giving a throughput of one division per 34 cycles.
- Divide by zero: `done`=`div_zero`=1 during the cycle after E0, then IDLE at E1.
- `hi`/`lo` are stable outside the completing edge and remain valid until the next completion or reset.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration

- `DIV_UNSIGNED_EN` defined:
  - The `is_unsigned` port exists.
  - With `is_unsigned`=1, operands are used as unsigned: no absolute value and no sign correction. This implements `divu`.
  - Latency is identical in both modes.
- Undefined: the port is absent and all divisions are signed.

## Test plan

- Basic signed: a=100, b=7, start 1 cycle → `done` in the cycle after E32; `lo`=14, `hi`=2, `div_zero`=0, `busy` drops at E33.
- Negative dividend: a=0xFFFFFF9C (−100), b=7 → `lo`=0xFFFFFFF2 (−14), `hi`=0xFFFFFFFE (−2).
- Negative divisor: a=100, b=0xFFFFFFF9 (−7) → `lo`=0xFFFFFFF2, `hi`=2.
- Divide by zero after a valid result of lo=14/hi=2: a=5, b=0 → `done`=`div_zero`=1 in the cycle after E0; `lo`=14 and `hi`=2 unchanged.
- Overflow and ignored requests:
  - a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
  - Re-pulse `start` at E10 with a=1, b=1 → ignored; the first result is unaffected.
  - Pull `reset` low at E20 → all outputs 0 immediately, no `done`.
- With `DIV_UNSIGNED_EN`:
  - is_unsigned=1, a=0xFFFFFFFF, b=2 → `lo`=0x7FFFFFFF, `hi`=1.
  - Same operands with is_unsigned=0 → `lo`=0, `hi`=0xFFFFFFFF.

Source files
------------

// File: rtl/divider_seq_if.sv
// Request/result bundle for divider_seq. The is_unsigned field exists only when
// DIV_UNSIGNED_EN is defined.
interface divider_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef DIV_UNSIGNED_EN
    logic             is_unsigned;
`endif
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, a, b,
`ifdef DIV_UNSIGNED_EN
        output is_unsigned,
`endif
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, a, b,
`ifdef DIV_UNSIGNED_EN
        input  is_unsigned,
`endif
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/divider_seq.sv
// Sequential restoring divider: one quotient bit per clock, lo = quotient, hi = remainder.
// Optional DIV_UNSIGNED_EN adds the is_unsigned request field (divu).
module divider_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clock,
    input  logic         reset,
    divider_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             zero_q;

    logic             uns;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] dvd_nx;

    always_comb begin
`ifdef DIV_UNSIGNED_EN
        uns = bus.is_unsigned;
`else
        uns = 1'b0;
`endif
        a_abs  = (!uns && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_abs  = (!uns && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        rem_sh = {rem, dvd[WIDTH-1]};
        // rem_sh < 2*dvs, so the top bit of the W+1 bit difference is the borrow
        trial  = rem_sh - {1'b0, dvs};
        fits   = !trial[WIDTH];
        rem_nx = fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        dvd_nx = {dvd[WIDTH-2:0], fits};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            dvd          <= '0;
            rem          <= '0;
            dvs          <= '0;
            cnt          <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            zero_q       <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.hi       <= '0;
            bus.lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        if (bus.b == '0) begin
                            zero_q       <= 1'b1;
                            bus.done     <= 1'b1;
                            bus.div_zero <= 1'b1;
                            state        <= DONE;
                        end else begin
                            zero_q <= 1'b0;
                            dvd    <= a_abs;
                            dvs    <= b_abs;
                            rem    <= '0;
                            neg_q  <= !uns && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            neg_r  <= !uns && bus.a[WIDTH-1];
                            cnt    <= CW'(WIDTH);
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    dvd <= dvd_nx;
                    rem <= rem_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        // -2^31 / -1 falls out naturally: magnitude 2^31, no negation
                        bus.lo       <= neg_q ? -dvd_nx : dvd_nx;
                        bus.hi       <= neg_r ? -rem_nx : rem_nx;
                        bus.done     <= 1'b1;
                        bus.div_zero <= zero_q;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    bus.done     <= 1'b0;
                    bus.div_zero <= 1'b0;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed corner cases plus random operands
// against an arithmetic reference model.
module tb_divider_seq;
    localparam int W = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [W-1:0] exp_lo = '0;
    logic [W-1:0] exp_hi = '0;

    divider_seq_if #(.WIDTH(W)) bus ();
    divider_seq #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: 64-bit signed arithmetic, so -2^31 / -1 yields 2^31 whose low word is 0x80000000
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic uns, output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb, lq, lr;
        if (uns) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[W-1:0];
            r  = lr[W-1:0];
        end
    endfunction

    task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
`ifdef DIV_UNSIGNED_EN
        bus.is_unsigned = uns;
`else
        if (uns) $error("FAIL drive_req: unsigned request in signed-only build");
`endif
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic uns, input bit repulse);
        logic [W-1:0] q, r;
        @(negedge clock);
        drive_req(a, b, uns);
        @(posedge clock);  // E0
        #1;
        bus.start = 1'b0;
        if (b == '0) begin
            check("dz_done", bus.done, 1);
            check("dz_flag", bus.div_zero, 1);
            check("dz_busy", bus.busy, 1);
            check("dz_lo_kept", bus.lo, exp_lo);
            check("dz_hi_kept", bus.hi, exp_hi);
            @(posedge clock);
            #1;
            check("dz_idle_done", bus.done, 0);
            check("dz_idle_flag", bus.div_zero, 0);
            check("dz_idle_busy", bus.busy, 0);
            return;
        end
        ref_div(a, b, uns, q, r);
        check("e0_busy", bus.busy, 1);
        check("e0_done", bus.done, 0);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clock);
            // operand churn after acceptance must not matter; optional ignored re-request at E10
            bus.start = repulse && (k == 10);
            bus.a     = (k == 10 && repulse) ? 32'd1 : $urandom;
            bus.b     = (k == 10 && repulse) ? 32'd1 : $urandom;
            @(posedge clock);
            #1;
            if (k < 32) begin
                if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                    check("run_done_early", bus.done, 0);
                    check("run_busy", bus.busy, 1);
                end
            end
        end
        check("fin_done", bus.done, 1);
        check("fin_busy", bus.busy, 1);
        check("fin_dz", bus.div_zero, 0);
        check("fin_lo", bus.lo, q);
        check("fin_hi", bus.hi, r);
        @(negedge clock);
        bus.start = 1'b0;
        @(posedge clock);  // E33
        #1;
        check("e33_busy", bus.busy, 0);
        check("e33_done", bus.done, 0);
        check("e33_lo_hold", bus.lo, q);
        exp_lo = q;
        exp_hi = r;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit saw_done;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
`ifdef DIV_UNSIGNED_EN
        bus.is_unsigned = 1'b0;
`endif
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dz", bus.div_zero, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_hi", bus.hi, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        run_div(32'd100, 32'd7, 1'b0, 1'b0);
        check("basic_lo", exp_lo, 32'd14);
        check("basic_hi", exp_hi, 32'd2);
        run_div(32'd5, 32'd0, 1'b0, 1'b0);
        check("dz_lo_const", bus.lo, 32'd14);
        check("dz_hi_const", bus.hi, 32'd2);
        run_div(32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0);
        check("negdvd_lo", bus.lo, 32'hFFFF_FFF2);
        check("negdvd_hi", bus.hi, 32'hFFFF_FFFE);
        run_div(32'd100, 32'hFFFF_FFF9, 1'b0, 1'b0);
        check("negdvs_lo", bus.lo, 32'hFFFF_FFF2);
        check("negdvs_hi", bus.hi, 32'd2);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        check("ovf_lo", bus.lo, 32'h8000_0000);
        check("ovf_hi", bus.hi, 32'd0);

        // Abort: reset at E20 clears everything and no done appears
        @(negedge clock);
        drive_req(32'd100, 32'd7, 1'b0);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_dz", bus.div_zero, 0);
        check("abort_lo", bus.lo, 0);
        check("abort_hi", bus.hi, 0);
        @(negedge clock);
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        exp_lo = '0;
        exp_hi = '0;

        for (int i = 0; i < 24; i++) begin
            ra = (i % 3 == 0) ? W'($urandom_range(0, 1000)) : W'($urandom);
            case ($urandom_range(0, 4))
                0, 1: rb = $urandom;
                2:    rb = W'($urandom_range(1, 20));
                3:    rb = -W'($urandom_range(1, 20));
                default: rb = '0;
            endcase
            run_div(ra, rb, 1'b0, 1'b0);
        end

`ifdef DIV_UNSIGNED_EN
        run_div(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        check("divu_lo", bus.lo, 32'h7FFF_FFFF);
        check("divu_hi", bus.hi, 32'd1);
        run_div(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        check("div_lo", bus.lo, 32'd0);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? W'($urandom) : W'($urandom_range(1, 50));
            run_div(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
